// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - per-register latency scoreboard with forwarding selects and stall detection
//
// Purpose:
//   Issue-stage hazard unit. Every in-flight register write is tracked by a
//   countdown of the cycles left until it reaches the register file, so
//   producers of any latency up to MAX_LAT are covered. Each source operand
//   gets a forwarding select or causes a RAW stall. A write that would land
//   before an older pending write to the same register causes a WAW stall.
//   Stalled issue cycles are counted in a saturating counter.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          synchronous active-high reset
//   issue_valid_i  instruction in ID requests issue
//   issue_ready_o  no hazard; issue accepted when valid && ready
//   src_en_i       per-operand "reads a register" flag
//   src_addr_i     packed source addresses, operand i at [i*REG_AW +: REG_AW]
//   dst_we_i       instruction writes a register
//   dst_addr_i     destination register
//   dst_lat_i      cycles until the result is in the register file
//   fwd_sel_o      per-operand select: 00 regfile, 01 EX/MEM, 10 MEM/WB
//   stall_cnt_o    saturating count of stalled issue cycles

module hazard_scoreboard #(
  parameter int REG_AW   = 5,
  parameter int NUM_SRC  = 2,
  parameter int MAX_LAT  = 4,
  parameter int STALL_CW = 16,
  localparam int CW      = $clog2(MAX_LAT + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      issue_valid_i,
  output logic                      issue_ready_o,
  input  logic [NUM_SRC-1:0]        src_en_i,
  input  logic [NUM_SRC*REG_AW-1:0] src_addr_i,
  input  logic                      dst_we_i,
  input  logic [REG_AW-1:0]         dst_addr_i,
  input  logic [CW-1:0]             dst_lat_i,
  output logic [2*NUM_SRC-1:0]      fwd_sel_o,
  output logic [STALL_CW-1:0]       stall_cnt_o
);

  localparam int            NUM_REG   = 1 << REG_AW;
  localparam logic [CW-1:0] MAX_LAT_C = CW'(MAX_LAT);

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EXM = 2'b01;
  localparam logic [1:0] FWD_MWB = 2'b10;

  // Remaining cycles until the pending write to each register lands; 0 = none.
  logic [CW-1:0]       cnt [NUM_REG];
  logic [STALL_CW-1:0] stall_cnt;

  logic [CW-1:0]     eff_lat;
  logic [CW-1:0]     dst_cnt;
  logic              raw_stall;
  logic              waw_stall;
  logic              set_en;
  logic [NUM_SRC-1:0] src_raw;

  logic [REG_AW-1:0] src_addr [NUM_SRC];
  logic [CW-1:0]     src_cnt  [NUM_SRC];

  // Latencies beyond the deepest producer are clamped rather than rejected.
  always_comb begin
    eff_lat = dst_lat_i;
    if (dst_lat_i > MAX_LAT_C) begin
      eff_lat = MAX_LAT_C;
    end
  end

  assign dst_cnt = cnt[dst_addr_i];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign src_addr[gi] = src_addr_i[gi*REG_AW +: REG_AW];
      assign src_cnt[gi]  = cnt[src_addr[gi]];

      // Count 1 means the value is leaving MEM/WB this cycle, count 2 means
      // it is in EX/MEM; anything older has not been produced yet.
      always_comb begin
        fwd_sel_o[2*gi +: 2] = FWD_RF;
        src_raw[gi]          = 1'b0;
        if (src_en_i[gi] && (src_addr[gi] != '0)) begin
          if (32'(src_cnt[gi]) == 32'd1) begin
            fwd_sel_o[2*gi +: 2] = FWD_MWB;
          end else if (32'(src_cnt[gi]) == 32'd2) begin
            fwd_sel_o[2*gi +: 2] = FWD_EXM;
          end else if (32'(src_cnt[gi]) >= 32'd3) begin
            src_raw[gi] = 1'b1;
          end
        end
      end
    end
  endgenerate

  assign raw_stall = |src_raw;

  // An older write still further out than this one would overwrite the
  // newer result, so hold issue until it has caught up.
  assign waw_stall = dst_we_i && (dst_addr_i != '0) && (dst_cnt > eff_lat);

  assign issue_ready_o = !(raw_stall || waw_stall);

  assign set_en = issue_valid_i && issue_ready_o && dst_we_i &&
                  (dst_addr_i != '0) && (eff_lat != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < NUM_REG; r++) begin
        cnt[r] <= '0;
      end
      stall_cnt <= '0;
    end else begin
      // Register 0 is never written, so its entry stays at zero.
      cnt[0] <= '0;
      for (int r = 1; r < NUM_REG; r++) begin
        if (set_en && (dst_addr_i == REG_AW'(r))) begin
          cnt[r] <= eff_lat;
        end else if (cnt[r] != '0) begin
          cnt[r] <= cnt[r] - 1'b1;
        end
      end
      if (issue_valid_i && !issue_ready_o && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

  assign stall_cnt_o = stall_cnt;

endmodule
